// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer sequencer.
// Contents:
//   src_e       : source now playing (none, key, bt, alarm)
//   state_e     : sequencer FSM states
//   step_t      : one ROM note step {half period, duration in ms, last flag}
//   PATTERN_ROM : note patterns for all three sources
//   *_START     : first ROM index of each source's pattern
package buzz_pkg;

   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_KEY   = 2'd1,
      SRC_BT    = 2'd2,
      SRC_ALARM = 2'd3
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } state_e;

   typedef struct packed {
      logic [15:0] hp;
      logic [11:0] dur_ms;
      logic        last;
   } step_t;

   localparam int PTR_W = 3;

   localparam logic [PTR_W-1:0] KEY_START   = 3'd0;
   localparam logic [PTR_W-1:0] BT_START    = 3'd1;
   localparam logic [PTR_W-1:0] ALARM_START = 3'd4;

   localparam logic [2:0] ACK_KEY   = 3'b001;
   localparam logic [2:0] ACK_BT    = 3'b010;
   localparam logic [2:0] ACK_ALARM = 3'b100;

   // hp = 0 marks a rest step.
   localparam step_t PATTERN_ROM [8] = '{
      '{hp: 16'd25000, dur_ms: 12'd30,  last: 1'b1},  // key
      '{hp: 16'd25000, dur_ms: 12'd80,  last: 1'b0},  // bt
      '{hp: 16'd0,     dur_ms: 12'd40,  last: 1'b0},
      '{hp: 16'd20000, dur_ms: 12'd80,  last: 1'b1},
      '{hp: 16'd20000, dur_ms: 12'd200, last: 1'b0},  // alarm
      '{hp: 16'd0,     dur_ms: 12'd100, last: 1'b0},
      '{hp: 16'd20000, dur_ms: 12'd200, last: 1'b0},
      '{hp: 16'd0,     dur_ms: 12'd500, last: 1'b1}
   };

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator for the buzzer pin.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   tone_en      : run the counter; when low, counter and output are held at 0
//   half_period  : half period in clk cycles
//   load         : restart the counter from 0 (new note step)
//   pwm_sig      : square wave, toggles every half_period cycles
module tone_gen #(
   parameter int HP_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tone_en,
   input  logic [HP_W-1:0] half_period,
   input  logic            load,
   output logic            pwm_sig
);

   logic [HP_W-1:0] cnt_q;
   logic            pwm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else if (load || !tone_en) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else if (cnt_q == half_period - HP_W'(1)) begin
         cnt_q <= '0;
         pwm_q <= ~pwm_q;
      end else begin
         cnt_q <= cnt_q + HP_W'(1);
      end
   end

   // Gating with tone_en keeps the pin low in the very first cycle of
   // IDLE/LOAD, before the registered level has been cleared.
   assign pwm_sig = pwm_q & tone_en;

endmodule

// File: rtl/buzzer_sequencer.sv
// Buzzer sequencer: arbitrates alarm > bt > key and plays the granted
// source's ROM note pattern, one step per LOAD/PLAY pair, in ms units.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_alarm    : level request, pattern loops while high, preempts bt/key
//   req_bt       : pulse request, latched into a pending flag
//   req_key      : pulse request, latched into a pending flag
//   mute         : (BUZZ_MUTE_EN only) forces pwm_sig low
//   ack          : 1-cycle grant pulse {alarm, bt, key}
//   busy         : high outside IDLE
//   src          : source now playing (0 none, 1 key, 2 bt, 3 alarm)
//   half_period  : half period of the current step, 0 = rest
//   tone_en      : high in PLAY on a non-rest step
//   pwm_sig      : buzzer output
// Build option: define BUZZ_MUTE_EN to add the mute input.
module buzzer_sequencer
   import buzz_pkg::*;
#(
   parameter int MS_DIV = 100_000,
   parameter int HP_W   = 16,
   parameter int DUR_W  = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_alarm,
   input  logic            req_bt,
   input  logic            req_key,
`ifdef BUZZ_MUTE_EN
   input  logic            mute,
`endif
   output logic [2:0]      ack,
   output logic            busy,
   output logic [1:0]      src,
   output logic [HP_W-1:0] half_period,
   output logic            tone_en,
   output logic            pwm_sig
);

   localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

   state_e            state_q, state_d;
   src_e              src_q, src_d;
   logic [PTR_W-1:0]  step_ptr_q, step_ptr_d;
   logic [2:0]        ack_q, ack_d;
   logic              pend_bt_q, pend_bt_d;
   logic              pend_key_q, pend_key_d;
   logic              alarm_prev_q;
   logic [HP_W-1:0]   hp_q;
   logic [DUR_W-1:0]  dur_q;
   logic [PRE_W-1:0]  pre_q;
   logic [DUR_W-1:0]  ms_q;

   step_t cur_step;
   logic  alarm_rise;
   logic  preempt;
   logic  step_end;
   logic  pwm_raw;

   assign cur_step   = PATTERN_ROM[step_ptr_q];
   assign alarm_rise = req_alarm & ~alarm_prev_q;
   // Only a fresh alarm edge aborts a bt/key pattern; the aborted source is dropped.
   assign preempt    = alarm_rise && (src_q != SRC_ALARM);
   assign step_end   = (state_q == ST_PLAY) && (pre_q == PRE_LAST) &&
                       (ms_q == dur_q - DUR_W'(1));

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      step_ptr_d = step_ptr_q;
      ack_d      = 3'b000;
      pend_bt_d  = pend_bt_q | req_bt;
      pend_key_d = pend_key_q | req_key;

      case (state_q)
         ST_IDLE: begin
            if (req_alarm) begin
               ack_d      = ACK_ALARM;
               src_d      = SRC_ALARM;
               step_ptr_d = ALARM_START;
               state_d    = ST_LOAD;
            end else if (pend_bt_q || req_bt) begin
               ack_d      = ACK_BT;
               src_d      = SRC_BT;
               step_ptr_d = BT_START;
               pend_bt_d  = 1'b0;
               state_d    = ST_LOAD;
            end else if (pend_key_q || req_key) begin
               ack_d      = ACK_KEY;
               src_d      = SRC_KEY;
               step_ptr_d = KEY_START;
               pend_key_d = 1'b0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD, ST_PLAY: begin
            if (preempt) begin
               ack_d      = ACK_ALARM;
               src_d      = SRC_ALARM;
               step_ptr_d = ALARM_START;
               state_d    = ST_LOAD;
            end else if (state_q == ST_LOAD) begin
               state_d = ST_PLAY;
            end else if (step_end) begin
               // A released alarm stops at the end of the current step.
               if (!cur_step.last && (src_q != SRC_ALARM || req_alarm)) begin
                  step_ptr_d = step_ptr_q + PTR_W'(1);
                  state_d    = ST_LOAD;
               end else if (cur_step.last && src_q == SRC_ALARM && req_alarm) begin
                  step_ptr_d = ALARM_START;
                  state_d    = ST_LOAD;
               end else begin
                  src_d   = SRC_NONE;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            src_d   = SRC_NONE;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         src_q        <= SRC_NONE;
         step_ptr_q   <= '0;
         ack_q        <= 3'b000;
         pend_bt_q    <= 1'b0;
         pend_key_q   <= 1'b0;
         alarm_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         step_ptr_q   <= step_ptr_d;
         ack_q        <= ack_d;
         pend_bt_q    <= pend_bt_d;
         pend_key_q   <= pend_key_d;
         alarm_prev_q <= req_alarm;
      end
   end

   // Step timing: PLAY lasts dur_q ms, counted by prescaler pre_q and ms counter ms_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         hp_q  <= '0;
         dur_q <= '0;
         pre_q <= '0;
         ms_q  <= '0;
      end else if (state_q == ST_LOAD) begin
         hp_q  <= HP_W'(cur_step.hp);
         dur_q <= DUR_W'(cur_step.dur_ms);
         pre_q <= '0;
         ms_q  <= '0;
      end else if (state_q == ST_PLAY) begin
         if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            ms_q  <= ms_q + DUR_W'(1);
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
      end
   end

   assign ack         = ack_q;
   assign busy        = (state_q != ST_IDLE);
   assign src         = src_q;
   assign half_period = hp_q;
   assign tone_en     = (state_q == ST_PLAY) && (hp_q != '0);

   tone_gen #(.HP_W(HP_W)) u_tone_gen (
      .clk         (clk),
      .rst         (rst),
      .tone_en     (tone_en),
      .half_period (hp_q),
      .load        (state_q == ST_LOAD),
      .pwm_sig     (pwm_raw)
   );

`ifdef BUZZ_MUTE_EN
   assign pwm_sig = pwm_raw & ~mute;
`else
   assign pwm_sig = pwm_raw;
`endif

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Testbench for buzzer_sequencer. Main instance uses MS_DIV = 10; a second
// instance with MS_DIV = 100000 runs alongside to time the square wave.
// Optional build: BUZZ_MUTE_EN adds the mute checks.
module tb_buzzer_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_alarm, req_bt, req_key;
   logic [2:0]  ack;
   logic        busy;
   logic [1:0]  src;
   logic [15:0] half_period;
   logic        tone_en, pwm_sig;

   logic        rst5, req_key5;
   logic        req_alarm5 = 1'b0;
   logic        req_bt5    = 1'b0;
   logic [2:0]  ack5;
   logic        busy5;
   logic [1:0]  src5;
   logic [15:0] hp5;
   logic        tone5, pwm5;
`ifdef BUZZ_MUTE_EN
   logic        mute;
   logic        mute5 = 1'b0;
`endif

   buzzer_sequencer #(.MS_DIV(10), .HP_W(16), .DUR_W(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_alarm   (req_alarm),
      .req_bt      (req_bt),
      .req_key     (req_key),
`ifdef BUZZ_MUTE_EN
      .mute        (mute),
`endif
      .ack         (ack),
      .busy        (busy),
      .src         (src),
      .half_period (half_period),
      .tone_en     (tone_en),
      .pwm_sig     (pwm_sig)
   );

   buzzer_sequencer #(.MS_DIV(100000), .HP_W(16), .DUR_W(12)) dut5 (
      .clk         (clk),
      .rst         (rst5),
      .req_alarm   (req_alarm5),
      .req_bt      (req_bt5),
      .req_key     (req_key5),
`ifdef BUZZ_MUTE_EN
      .mute        (mute5),
`endif
      .ack         (ack5),
      .busy        (busy5),
      .src         (src5),
      .half_period (hp5),
      .tone_en     (tone5),
      .pwm_sig     (pwm5)
   );

   typedef struct packed {
      logic [2:0]  ack;
      logic [1:0]  src;
      logic [15:0] hp;
   } exp_t;

   typedef struct {
      logic       a, b, k;
      logic [1:0] g0, g1, g2;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[4];

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic hp_due = 1'b0;
   logic [15:0] hp_exp = '0;

   int   t5_rise = -1;
   int   t5_tog[$];
   logic tone5_prev = 1'b0;
   logic pwm5_prev = 1'b0;

   function automatic exp_t exp_for(input logic [1:0] s);
      exp_t e;
      case (s)
         2'd1:    e = '{ack: 3'b001, src: 2'd1, hp: 16'd25000};
         2'd2:    e = '{ack: 3'b010, src: 2'd2, hp: 16'd25000};
         default: e = '{ack: 3'b100, src: 2'd3, hp: 16'd20000};
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: outputs sampled at the falling edge, scoreboard checks grants.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (hp_due) begin
         chk("grant_hp", {16'd0, half_period}, {16'd0, hp_exp});
         chk("grant_tone_en", {31'd0, tone_en}, {31'd0, hp_exp != 16'd0});
         hp_due = 1'b0;
      end
      if (ack !== 3'b000) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", {29'd0, ack}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("ack", {29'd0, ack}, {29'd0, e.ack});
            chk("src", {30'd0, src}, {30'd0, e.src});
            hp_due = 1'b1;
            hp_exp = e.hp;
         end
      end
      if (tone5 && !tone5_prev) t5_rise = cyc;
      if (pwm5 !== pwm5_prev) t5_tog.push_back(cyc);
      tone5_prev = tone5;
      pwm5_prev  = pwm5;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40000) begin
         tick();
         n++;
      end
   endtask

   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (tone_en === lvl && busy && n < 20000) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_drain();
      int n, idle;
      n = 0;
      idle = 0;
      while (idle < 3 && n < 20000) begin
         tick();
         n++;
         if (busy) idle = 0;
         else      idle++;
      end
      chk("drain_timeout", {31'd0, n < 20000}, 32'd1);
      chk("drain_sb_empty", sb_q.size(), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},  {29'd0, ack}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_src"},  {30'd0, src}, 32'd0);
      chk({tag, "_hp"},   {16'd0, half_period}, 32'd0);
      chk({tag, "_tone"}, {31'd0, tone_en}, 32'd0);
      chk({tag, "_pwm"},  {31'd0, pwm_sig}, 32'd0);
   endtask

   initial begin
      int  n, busy_cnt;
      logic saw_bt;

      vecs[0] = '{a: 1'b0, b: 1'b0, k: 1'b1, g0: 2'd1, g1: 2'd0, g2: 2'd0};
      vecs[1] = '{a: 1'b0, b: 1'b1, k: 1'b0, g0: 2'd2, g1: 2'd0, g2: 2'd0};
      vecs[2] = '{a: 1'b1, b: 1'b0, k: 1'b1, g0: 2'd3, g1: 2'd1, g2: 2'd0};
      vecs[3] = '{a: 1'b1, b: 1'b1, k: 1'b1, g0: 2'd3, g1: 2'd2, g2: 2'd1};

      rst = 1'b1; req_alarm = 1'b0; req_bt = 1'b0; req_key = 1'b0;
      rst5 = 1'b1; req_key5 = 1'b0;
`ifdef BUZZ_MUTE_EN
      mute = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      rst5 = 1'b0;
      tick();
      chk_all_zero("reset");

      // Start the MS_DIV = 100000 instance playing the key pattern.
      req_key5 = 1'b1;
      tick();
      req_key5 = 1'b0;

      // Key pulse: ack next cycle, tone the cycle after, 300 PLAY cycles.
      sb_q.push_back(exp_for(2'd1));
      req_key = 1'b1;
      tick();
      req_key = 1'b0;
      chk("t1_ack", {29'd0, ack}, 32'd1);
      tick();
      chk("t1_tone", {31'd0, tone_en}, 32'd1);
      chk("t1_hp", {16'd0, half_period}, 32'd25000);
      wait_idle(n);
      chk("t1_play_len", n, 32'd300);
      chk("t1_src_none", {30'd0, src}, 32'd0);

      // bt and key together: bt pattern first, then key.
      sb_q.push_back(exp_for(2'd2));
      sb_q.push_back(exp_for(2'd1));
      req_bt = 1'b1; req_key = 1'b1;
      tick();
      req_bt = 1'b0; req_key = 1'b0;
      tick();
      run_len(1'b1, n);
      chk("t2_bt_tone1", n, 32'd800);
      run_len(1'b0, n);
      chk("t2_bt_rest", n, 32'd402);
      chk("t2_bt_hp3", {16'd0, half_period}, 32'd20000);
      run_len(1'b1, n);
      chk("t2_bt_tone3", n, 32'd800);
      chk("t2_gap_busy", {31'd0, busy}, 32'd0);
      chk("t2_gap_pwm", {31'd0, pwm_sig}, 32'd0);
      tick();
      chk("t2_key_ack", {29'd0, ack}, 32'd1);
      wait_idle(n);
      chk("t2_key_len", n, 32'd301);

      // Alarm preempts bt 500 cycles into playback; bt is dropped.
      sb_q.push_back(exp_for(2'd2));
      sb_q.push_back(exp_for(2'd3));
      req_bt = 1'b1;
      tick();
      req_bt = 1'b0;
      tick();
      repeat (499) tick();
      req_alarm = 1'b1;
      tick();
      chk("t3_ack", {29'd0, ack}, 32'd4);
      chk("t3_src", {30'd0, src}, 32'd3);
      req_alarm = 1'b0;
      tick();
      saw_bt = 1'b0;
      n = 0;
      while (busy && n < 40000) begin
         if (src == 2'd2) saw_bt = 1'b1;
         tick();
         n++;
      end
      chk("t3_alarm_step", n, 32'd2000);
      chk("t3_bt_resumed", {31'd0, saw_bt}, 32'd0);
      busy_cnt = 0;
      repeat (20) begin
         tick();
         if (busy) busy_cnt++;
      end
      chk("t3_stays_idle", busy_cnt, 32'd0);

      // Same-cycle request table: highest first, the rest follow.
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].g0 != 2'd0) sb_q.push_back(exp_for(vecs[i].g0));
         if (vecs[i].g1 != 2'd0) sb_q.push_back(exp_for(vecs[i].g1));
         if (vecs[i].g2 != 2'd0) sb_q.push_back(exp_for(vecs[i].g2));
         req_alarm = vecs[i].a; req_bt = vecs[i].b; req_key = vecs[i].k;
         tick();
         req_alarm = 1'b0; req_bt = 1'b0; req_key = 1'b0;
         wait_drain();
      end

      // Alarm held across loops, released in the 0/100 rest of loop 3.
      sb_q.push_back(exp_for(2'd3));
      req_alarm = 1'b1;
      tick();
      for (int i = 1; i <= 22500; i++) begin
         tick();
         if (i == 10005) begin
            chk("t4_loop2_hp", {16'd0, half_period}, 32'd20000);
            chk("t4_loop2_tone", {31'd0, tone_en}, 32'd1);
         end
      end
      chk("t4_in_rest_tone", {31'd0, tone_en}, 32'd0);
      chk("t4_in_rest_hp", {16'd0, half_period}, 32'd0);
      req_alarm = 1'b0;
      wait_idle(n);
      chk("t4_rest_finish", n, 32'd510);
      busy_cnt = 0;
      repeat (50) begin
         tick();
         if (busy || tone_en) busy_cnt++;
      end
      chk("t4_no_more_tone", busy_cnt, 32'd0);

      // Reset mid-alarm with bt and key pending: everything cleared.
      sb_q.push_back(exp_for(2'd3));
      req_alarm = 1'b1;
      tick();
      req_bt = 1'b1; req_key = 1'b1;
      tick();
      req_bt = 1'b0; req_key = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      req_alarm = 1'b0;
      tick();
      rst = 1'b0;
      chk_all_zero("t6_rst");
      busy_cnt = 0;
      repeat (30) begin
         tick();
         if (busy) busy_cnt++;
      end
      chk("t6_pend_cleared", busy_cnt, 32'd0);
      chk("t6_sb_empty", sb_q.size(), 32'd0);

`ifdef BUZZ_MUTE_EN
      // Muted key: timing unchanged, pin stays low.
      mute = 1'b1;
      sb_q.push_back(exp_for(2'd1));
      req_key = 1'b1;
      tick();
      req_key = 1'b0;
      tick();
      chk("mute_tone", {31'd0, tone_en}, 32'd1);
      n = 0;
      busy_cnt = 0;
      while (busy && n < 40000) begin
         if (pwm_sig) busy_cnt++;
         tick();
         n++;
      end
      chk("mute_len", n, 32'd300);
      chk("mute_pwm_low", busy_cnt, 32'd0);
      mute = 1'b0;
`endif

      // Square-wave timing on the MS_DIV = 100000 instance.
      n = 0;
      while (t5_tog.size() < 2 && n < 60000) begin
         tick();
         n++;
      end
      chk("t5_timeout", {31'd0, t5_tog.size() >= 2}, 32'd1);
      if (t5_tog.size() >= 2) begin
         chk("t5_first_toggle", t5_tog[0] - t5_rise, 32'd25000);
         chk("t5_second_toggle", t5_tog[1] - t5_tog[0], 32'd25000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
